ps_seq_core: RTL and testbench
==============================

// Module: ps_seq_core
// PURPOSE
//  Parametrised program-sequencer core: owns the fetch/decode/execute address pipeline (faddr->daddr->pc),
//  drives the PM fetch address, and adds jump/call/return redirection, a DEPTH-deep PC stack with
//  push/pop and overwrite, and idle/interrupt wake. Sits between the PM and the instruction decoders.
// PARAMETERS
//  AW       16  address width of faddr/daddr/pc/stack entries
//  DEPTH    4   PC stack entries; power of 2, >=2
//  PW       $clog2(DEPTH+1)  stack pointer width; counts 0..DEPTH
//  RST_VEC  0   faddr value after reset
//  IRQ_VEC  0   wake target when WAKE_VEC=1
//  WAKE_VEC 0   0: wake resumes at held faddr; 1: wake redirects to IRQ_VEC
// PORTS
//  clk         in   1    clock
//  rst         in   1    reset, asynchronous, active-low
//  jmp_req     in   1    jump from instruction in pc stage
//  call_req    in   1    call: push pc+1, redirect
//  rts_req     in   1    return: redirect to stack top, pop
//  tgt         in   AW   jump/call target
//  push_req    in   1    ureg push of push_dt
//  pop_req     in   1    ureg pop
//  push_dt     in   AW   data for push_req
//  top_wr      in   1    overwrite top entry (empty: entry 0) with push_dt
//  idle_req    in   1    IDLE instruction in pc stage
//  interrupt   in   1    wake request
//  stcky_clr   in   1    clear underflow/overflow stickies
//  pm_add      out  AW   PM fetch address (=faddr)
//  pm_cslt     out  1    PM chip select (=!idle)
//  faddr,daddr,pc out AW pipeline addresses
//  pc_vld      out  1    pc stage holds a real (non-flushed) instruction
//  stk_top     out  AW   top entry; 0 when empty
//  stk_ptr     out  PW   occupied entries
//  stcky       out  4    {underflow, overflow, full, empty}
//  idle        out  1    sequencer idle
// BEHAVIOUR
//  - Reset: faddr=RST_VEC, daddr=pc=0, d_vld=pc_vld=0, stk_ptr=0, stcky=4'b0001, idle=0; stack RAM not cleared.
//  - Request inputs are ignored unless pc_vld=1 and idle=0 (interrupt, stcky_clr excepted).
//  - Normal: per clk when !idle: faddr+=1 (wraps 2^AW-1 -> 0), daddr<=faddr, pc<=daddr, valids shift.
//  - Redirect priority call > rts > jmp. On redirect: faddr<=target, daddr<=faddr+1 and pc<=daddr advance
//    but d_vld, pc_vld<=0 (two bubbles); first valid target in pc after 3 clocks.
//  - call: pushes pc+1 (wrap). rts: target=stk_top, pops. Conflicting push_req/pop_req ignored on redirect cycles.
//  - Push when stk_ptr==DEPTH: no write, ptr held, overflow<=1. Pop/rts when empty: ptr held, underflow<=1,
//    rts target 0. full=(ptr==DEPTH), empty=(ptr==0), registered, exact every cycle.
//  - push_req & pop_req same cycle: top replaced by push_dt, ptr unchanged, no flag change (empty: acts as push).
//  - top_wr with push/pop same cycle: top_wr ignored. Stack writes visible on stk_top next cycle.
//  - Stickies hold until stcky_clr; clr and new set same cycle: set wins.
//  - idle_req: idle<=1 next clk; pipeline and stack freeze, pm_cslt=0. interrupt while idle: idle<=0 next clk;
//    WAKE_VEC=1 additionally redirects to IRQ_VEC (bubbles as above). interrupt with idle=0: no effect.
//  - Async reset mid-redirect/mid-idle returns to reset state immediately; no partial stack update.
// STRUCTURE
//  - ps_pkg: stcky bit index constants (STK_EMPTY=0, STK_FULL=1, STK_OVF=2, STK_UNF=3), redirect-cause enum.
//  - Sub-module ps_pc_stack (DEPTH x AW regs, ptr, full/empty/ovf/unf, push/pop/top_wr); rest is pipeline + idle FSM
//    (RUN, IDLE).
// TESTING
//  - Reset then 5 clks -> faddr=5, daddr=4, pc=3, pc_vld=1, stcky=4'b0001.
//  - call tgt=0x0100 at pc=0x0010 -> stk_top=0x0011, ptr=1, pc_vld low 2 clks, pc=0x0100 after 3 clks; rts -> pc=0x0011.
//  - DEPTH=4: 5 push_req -> ptr=4, full=1, overflow=1, stk_top=4th value; stcky_clr -> overflow=0, full stays 1.
//  - rts on empty -> faddr=0, underflow=1, ptr=0; push+pop same cycle at ptr=2 -> ptr=2, top=push_dt.
//  - idle_req then 10 clks -> faddr frozen, pm_cslt=0; interrupt -> idle=0 next clk, faddr resumes (WAKE_VEC=1: IRQ_VEC).
//  - faddr=0xFFFF with AW=16 -> next faddr=0x0000; rst low mid-redirect -> reset values immediately.

Source files
------------

// File: rtl/ps_pkg.sv
// ps_pkg: shared definitions for the program-sequencer core.
//   STK_*      bit positions inside the 4-bit stcky status word
//   redir_e    why the fetch address is being redirected this cycle
//   seq_st_e   run/idle state of the sequencer
package ps_pkg;

  localparam int STK_EMPTY = 0;
  localparam int STK_FULL  = 1;
  localparam int STK_OVF   = 2;
  localparam int STK_UNF   = 3;

  typedef enum logic [2:0] {
    RD_NONE,
    RD_JMP,
    RD_CALL,
    RD_RTS,
    RD_WAKE
  } redir_e;

  typedef enum logic {
    S_RUN,
    S_IDLE
  } seq_st_e;

endpackage

// File: rtl/ps_pc_stack.sv
// ps_pc_stack: DEPTH-entry PC stack with pointer and status flags.
//   clk, rst       clock, async active-low reset
//   push, pop      push wdata / pop top; both together replace the top
//   top_wr         overwrite top (entry 0 when empty); ignored with push/pop
//   stcky_clr      clear overflow/underflow stickies (a new set wins)
//   wdata          data for push / replace / top_wr
//   top            top entry, 0 when empty
//   ptr            occupied entries, 0..DEPTH
//   stcky          {underflow, overflow, full, empty}
// Entry storage has no reset; only ptr and flags are reset.
module ps_pc_stack
  import ps_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          top_wr,
  input  logic          stcky_clr,
  input  logic [AW-1:0] wdata,
  output logic [AW-1:0] top,
  output logic [PW-1:0] ptr,
  output logic [3:0]    stcky
);

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0][AW-1:0] mem;
  logic                     is_full, is_empty;
  logic [PW-1:0]            ptr_nxt;
  logic [IW-1:0]            top_idx, wr_idx;
  logic                     wr_en, ovf_set, unf_set;

  assign is_full  = (ptr == PW'(DEPTH));
  assign is_empty = (ptr == '0);
  assign top_idx  = IW'(ptr - PW'(1));
  assign top      = is_empty ? '0 : mem[top_idx];

  always_comb begin
    ptr_nxt = ptr;
    wr_en   = 1'b0;
    wr_idx  = IW'(ptr);
    ovf_set = 1'b0;
    unf_set = 1'b0;
    // push+pop on an empty stack degrades to a plain push
    if (push && (!pop || is_empty)) begin
      if (is_full) ovf_set = 1'b1;
      else begin
        wr_en   = 1'b1;
        ptr_nxt = ptr + PW'(1);
      end
    end else if (push && pop) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (pop) begin
      if (is_empty) unf_set = 1'b1;
      else          ptr_nxt = ptr - PW'(1);
    end else if (top_wr) begin
      wr_en  = 1'b1;
      wr_idx = is_empty ? '0 : top_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wdata;
  end

  // full/empty track the next pointer so they are exact on every cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      stcky <= 4'b0001;
    end else begin
      ptr              <= ptr_nxt;
      stcky[STK_EMPTY] <= (ptr_nxt == '0);
      stcky[STK_FULL]  <= (ptr_nxt == PW'(DEPTH));
      stcky[STK_OVF]   <= ovf_set | (stcky[STK_OVF] & ~stcky_clr);
      stcky[STK_UNF]   <= unf_set | (stcky[STK_UNF] & ~stcky_clr);
    end
  end

endmodule

// File: rtl/ps_seq_core.sv
// ps_seq_core: program-sequencer core.
//   Fetch/decode/execute address pipeline faddr->daddr->pc with jump/call/
//   return redirection, a PC stack and an idle/interrupt wake FSM.
//   clk, rst                 clock, async active-low reset
//   jmp_req/call_req/rts_req redirects from the pc-stage instruction
//   tgt                      jump/call target
//   push_req/pop_req/top_wr  user stack ops, data in push_dt
//   idle_req, interrupt      enter idle / wake from idle
//   stcky_clr                clear overflow/underflow stickies
//   pm_add, pm_cslt          PM fetch address and chip select
//   faddr, daddr, pc, pc_vld pipeline addresses, pc-stage valid
//   stk_top, stk_ptr, stcky  stack top, occupancy, status
//   idle                     sequencer idle
module ps_seq_core
  import ps_pkg::*;
#(
  parameter int          AW       = 16,
  parameter int          DEPTH    = 4,
  parameter int          PW       = $clog2(DEPTH + 1),
  parameter logic [AW-1:0] RST_VEC = '0,
  parameter logic [AW-1:0] IRQ_VEC = '0,
  parameter bit          WAKE_VEC = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jmp_req,
  input  logic          call_req,
  input  logic          rts_req,
  input  logic [AW-1:0] tgt,
  input  logic          push_req,
  input  logic          pop_req,
  input  logic [AW-1:0] push_dt,
  input  logic          top_wr,
  input  logic          idle_req,
  input  logic          interrupt,
  input  logic          stcky_clr,
  output logic [AW-1:0] pm_add,
  output logic          pm_cslt,
  output logic [AW-1:0] faddr,
  output logic [AW-1:0] daddr,
  output logic [AW-1:0] pc,
  output logic          pc_vld,
  output logic [AW-1:0] stk_top,
  output logic [PW-1:0] stk_ptr,
  output logic [3:0]    stcky,
  output logic          idle
);

  localparam int STAGES = 1;

  // vld_pipe[0]: decode stage valid, vld_pipe[STAGES]: pc stage valid
  logic [STAGES:0] vld_pipe;
  seq_st_e         st;
  redir_e          cause;
  logic            act, adv;
  logic [AW-1:0]   tgt_nxt, s_wdata;
  logic            s_push, s_pop, s_topwr;

  assign pc_vld  = vld_pipe[STAGES];
  assign pm_add  = faddr;
  assign pm_cslt = ~idle;

  // requests only count for a real instruction while running
  assign act = pc_vld && (st == S_RUN);

  always_comb begin
    cause   = RD_NONE;
    tgt_nxt = tgt;
    if (act) begin
      if (call_req)     cause = RD_CALL;
      else if (rts_req) begin
        cause   = RD_RTS;
        tgt_nxt = stk_top;
      end else if (jmp_req) cause = RD_JMP;
    end else if ((st == S_IDLE) && interrupt && WAKE_VEC) begin
      cause   = RD_WAKE;
      tgt_nxt = IRQ_VEC;
    end
  end

  // user stack ops are dropped on any redirect cycle
  always_comb begin
    s_push  = 1'b0;
    s_pop   = 1'b0;
    s_topwr = 1'b0;
    s_wdata = push_dt;
    unique case (cause)
      RD_CALL: begin
        s_push  = 1'b1;
        s_wdata = pc + AW'(1);
      end
      RD_RTS:  s_pop = 1'b1;
      RD_NONE: if (act) begin
        s_push  = push_req;
        s_pop   = pop_req;
        s_topwr = top_wr;
      end
      default: ;
    endcase
  end

  ps_pc_stack #(.AW(AW), .DEPTH(DEPTH), .PW(PW)) u_stk (
    .clk       (clk),
    .rst       (rst),
    .push      (s_push),
    .pop       (s_pop),
    .top_wr    (s_topwr),
    .stcky_clr (stcky_clr),
    .wdata     (s_wdata),
    .top       (stk_top),
    .ptr       (stk_ptr),
    .stcky     (stcky)
  );

  // a vectored wake advances the pipeline on the same edge it leaves idle
  assign adv = (st == S_RUN) || (cause == RD_WAKE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      faddr    <= RST_VEC;
      daddr    <= '0;
      pc       <= '0;
      vld_pipe <= '0;
    end else if (adv) begin
      pc <= daddr;
      if (cause != RD_NONE) begin
        faddr    <= tgt_nxt;
        daddr    <= faddr + AW'(1);
        vld_pipe <= '0;
      end else begin
        faddr    <= faddr + AW'(1);
        daddr    <= faddr;
        vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= S_RUN;
      idle <= 1'b0;
    end else begin
      unique case (st)
        S_RUN: if (act && idle_req) begin
          st   <= S_IDLE;
          idle <= 1'b1;
        end
        S_IDLE: if (interrupt) begin
          st   <= S_RUN;
          idle <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps_seq_core.sv
// tb_ps_seq_core: directed + randomized bench for ps_seq_core against a
// queue-based behavioural model (AW=16, DEPTH=4, WAKE_VEC=1, IRQ_VEC=0x0040).
module tb_ps_seq_core;

  localparam int          AW    = 16;
  localparam int          DEPTH = 4;
  localparam int          PW    = 3;
  localparam logic [15:0] IRQ   = 16'h0040;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          jmp_req, call_req, rts_req, push_req, pop_req, top_wr;
  logic          idle_req, interrupt, stcky_clr;
  logic [AW-1:0] tgt, push_dt;
  logic [AW-1:0] pm_add, faddr, daddr, pc, stk_top;
  logic          pm_cslt, pc_vld, idle;
  logic [PW-1:0] stk_ptr;
  logic [3:0]    stcky;

  ps_seq_core #(
    .AW(AW), .DEPTH(DEPTH), .PW(PW),
    .RST_VEC(16'h0000), .IRQ_VEC(IRQ), .WAKE_VEC(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .jmp_req(jmp_req), .call_req(call_req), .rts_req(rts_req), .tgt(tgt),
    .push_req(push_req), .pop_req(pop_req), .push_dt(push_dt), .top_wr(top_wr),
    .idle_req(idle_req), .interrupt(interrupt), .stcky_clr(stcky_clr),
    .pm_add(pm_add), .pm_cslt(pm_cslt), .faddr(faddr), .daddr(daddr), .pc(pc),
    .pc_vld(pc_vld), .stk_top(stk_top), .stk_ptr(stk_ptr), .stcky(stcky), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_test = 0;
  int n_fail = 0;

  // behavioural model
  logic [AW-1:0] m_f, m_d, m_pc;
  bit            m_dv, m_pv, m_idle, m_ovf, m_unf;
  logic [AW-1:0] m_stk[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_test++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] m_top();
    return (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
  endfunction

  task automatic st_push(logic [AW-1:0] v);
    if (m_stk.size() == DEPTH) m_ovf = 1'b1;
    else m_stk.push_back(v);
  endtask

  task automatic st_pop();
    if (m_stk.size() == 0) m_unf = 1'b1;
    else void'(m_stk.pop_back());
  endtask

  task automatic model_reset();
    m_f = 16'h0000; m_d = '0; m_pc = '0;
    m_dv = 0; m_pv = 0; m_idle = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
  endtask

  // advance the model by one clock using the currently driven inputs
  task automatic model_step();
    bit            act, red, nidle;
    logic [AW-1:0] t, nf, nd, np;
    act = m_pv && !m_idle;
    red = 0;
    t   = '0;
    if (stcky_clr) begin m_ovf = 0; m_unf = 0; end
    if (act && call_req)       begin red = 1; t = tgt; st_push(m_pc + 16'd1); end
    else if (act && rts_req)   begin red = 1; t = m_top(); st_pop(); end
    else if (act && jmp_req)   begin red = 1; t = tgt; end
    else if (m_idle && interrupt) begin red = 1; t = IRQ; end
    if (act && !red) begin
      if (push_req && pop_req) begin
        if (m_stk.size() == 0) st_push(push_dt);
        else m_stk[m_stk.size()-1] = push_dt;
      end else if (push_req) st_push(push_dt);
      else if (pop_req) st_pop();
      else if (top_wr && m_stk.size() > 0) m_stk[m_stk.size()-1] = push_dt;
    end
    nidle = m_idle;
    if (m_idle && interrupt) nidle = 0;
    else if (act && idle_req) nidle = 1;
    if (!m_idle || red) begin
      np = m_d;
      if (red) begin nf = t; nd = m_f + 16'd1; m_pv = 0; m_dv = 0; end
      else begin nf = m_f + 16'd1; nd = m_f; m_pv = m_dv; m_dv = 1; end
      m_f = nf; m_d = nd; m_pc = np;
    end
    m_idle = nidle;
  endtask

  task automatic check_all(string ph);
    chk({ph, ".faddr"},   faddr,   m_f);
    chk({ph, ".daddr"},   daddr,   m_d);
    chk({ph, ".pc"},      pc,      m_pc);
    chk({ph, ".pc_vld"},  pc_vld,  m_pv);
    chk({ph, ".stk_top"}, stk_top, m_top());
    chk({ph, ".stk_ptr"}, stk_ptr, m_stk.size());
    chk({ph, ".stcky"},   stcky,   {m_unf, m_ovf, m_stk.size() == DEPTH, m_stk.size() == 0});
    chk({ph, ".idle"},    idle,    m_idle);
    chk({ph, ".pm_add"},  pm_add,  m_f);
    chk({ph, ".pm_cslt"}, pm_cslt, !m_idle);
  endtask

  task automatic clr_in();
    jmp_req = 0; call_req = 0; rts_req = 0; push_req = 0; pop_req = 0;
    top_wr = 0; idle_req = 0; interrupt = 0; stcky_clr = 0;
    tgt = '0; push_dt = '0;
  endtask

  task automatic cyc(string ph);
    model_step();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic wait_vld(string ph);
    for (int i = 0; i < 8 && !pc_vld; i++) cyc(ph);
    chk({ph, ".wait_vld"}, pc_vld, 1'b1);
  endtask

  logic [AW-1:0] pv[5];
  logic [AW-1:0] f0;

  initial begin
    clr_in();
    model_reset();
    #12;
    check_all("rst");
    @(negedge clk);
    rst = 1'b1;

    repeat (5) cyc("boot");
    chk("boot.faddr5", faddr, 16'd5);
    chk("boot.daddr4", daddr, 16'd4);
    chk("boot.pc3",    pc,    16'd3);
    chk("boot.vld",    pc_vld, 1'b1);
    chk("boot.stcky",  stcky, 4'b0001);

    // call from pc=0x0010 to 0x0100, then return
    for (int i = 0; i < 40 && !(pc == 16'h0010 && pc_vld); i++) cyc("run");
    chk("call.reach_pc", pc, 16'h0010);
    call_req = 1; tgt = 16'h0100;
    cyc("call");
    clr_in();
    chk("call.top", stk_top, 16'h0011);
    chk("call.ptr", stk_ptr, 3'd1);
    chk("call.bub0", pc_vld, 1'b0);
    cyc("call_b1");
    chk("call.bub1", pc_vld, 1'b0);
    cyc("call_b2");
    chk("call.pc", pc, 16'h0100);
    chk("call.vld", pc_vld, 1'b1);
    rts_req = 1;
    cyc("rts");
    clr_in();
    repeat (2) cyc("rts_b");
    chk("rts.pc", pc, 16'h0011);
    chk("rts.ptr", stk_ptr, 3'd0);

    // overflow: five pushes into a 4-deep stack
    for (int i = 0; i < 5; i++) begin
      pv[i] = 16'($urandom);
      push_req = 1; push_dt = pv[i];
      cyc("push");
    end
    clr_in();
    chk("ovf.ptr", stk_ptr, 3'd4);
    chk("ovf.full", stcky[1], 1'b1);
    chk("ovf.ovf", stcky[2], 1'b1);
    chk("ovf.top", stk_top, pv[3]);
    stcky_clr = 1;
    cyc("sclr");
    clr_in();
    chk("sclr.ovf", stcky[2], 1'b0);
    chk("sclr.full", stcky[1], 1'b1);

    // drain, then rts on empty
    repeat (4) begin pop_req = 1; cyc("pop"); end
    clr_in();
    rts_req = 1;
    cyc("rts_empty");
    clr_in();
    chk("unf.faddr", faddr, 16'h0000);
    chk("unf.unf", stcky[3], 1'b1);
    chk("unf.ptr", stk_ptr, 3'd0);
    wait_vld("unf");
    push_req = 1; push_dt = 16'h1111; cyc("pp1");
    push_dt = 16'h2222; cyc("pp2");
    pop_req = 1; push_dt = 16'h3333; cyc("pp3");
    clr_in();
    chk("pp.ptr", stk_ptr, 3'd2);
    chk("pp.top", stk_top, 16'h3333);

    // idle / vectored wake
    idle_req = 1;
    cyc("idle_req");
    clr_in();
    f0 = faddr;
    repeat (10) cyc("idle");
    chk("idle.frozen", faddr, f0);
    chk("idle.cslt", pm_cslt, 1'b0);
    chk("idle.idle", idle, 1'b1);
    interrupt = 1;
    cyc("wake");
    clr_in();
    chk("wake.idle", idle, 1'b0);
    chk("wake.faddr", faddr, IRQ);

    // faddr wrap
    wait_vld("wrap");
    jmp_req = 1; tgt = 16'hFFFE;
    cyc("jmp");
    clr_in();
    cyc("wrap1");
    chk("wrap.ffff", faddr, 16'hFFFF);
    cyc("wrap2");
    chk("wrap.zero", faddr, 16'h0000);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      call_req  = ($urandom_range(11) == 0);
      rts_req   = ($urandom_range(11) == 0);
      jmp_req   = ($urandom_range(15) == 0);
      push_req  = ($urandom_range(4) == 0);
      pop_req   = ($urandom_range(4) == 0);
      top_wr    = ($urandom_range(9) == 0);
      idle_req  = ($urandom_range(39) == 0);
      interrupt = ($urandom_range(5) == 0);
      stcky_clr = ($urandom_range(19) == 0);
      tgt       = 16'($urandom);
      push_dt   = 16'($urandom);
      cyc("rnd");
    end
    clr_in();

    // async reset in the middle of a redirect
    if (idle) begin interrupt = 1; cyc("pre_arst"); clr_in(); end
    wait_vld("arst");
    call_req = 1; tgt = 16'h0ABC;
    cyc("arst_call");
    clr_in();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    chk("arst.faddr", faddr, 16'h0000);
    chk("arst.stcky", stcky, 4'b0001);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) cyc("post_arst");

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
